// File: rtl/interrupt_ack_pkg.sv
// interrupt_ack_pkg: shared states and protocol constants for the INTA sequencer.
package interrupt_ack_pkg;
   typedef enum logic [1:0] {IDLE, LOW, GAP, RECOVER} state_t;
   localparam logic [7:0] CALL_OPCODE = 8'hCD;
   localparam logic [1:0] PULSES_8086 = 2'd2;
   localparam logic [1:0] PULSES_8080 = 2'd3;
endpackage

// File: rtl/inta_pulse_counter.sv
// inta_pulse_counter: loadable down-counter that stops at 1 and flags its terminal cycle.
module inta_pulse_counter #(
   parameter int W = 3
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         terminal
);
   logic [W-1:0] count_q, count_d;
   always_comb count_d = load ? load_value : ((count_q > W'(1)) ? count_q - W'(1) : count_q);
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) count_q <= '0;
      else count_q <= count_d;
   assign terminal = (count_q <= W'(1));
endmodule

// File: rtl/interrupt_acknowledge_sequencer.sv
// interrupt_acknowledge_sequencer: CPU-side 8259A INTA pulse generator with vector/CALL capture.
// Define INTA_SYNC_EN to pass int_request through a 2-flop synchronizer before sampling.
module interrupt_acknowledge_sequencer
   import interrupt_ack_pkg::*;
#(
   parameter int PULSE_WIDTH     = 2,
   parameter int GAP_WIDTH       = 2,
   parameter int RECOVERY_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        int_request,
   input  logic        interrupt_enable,
   input  logic        mode_8086,
   input  logic [7:0]  data_in,
   output logic        inta_n,
   output logic        busy,
   output logic [7:0]  vector,
   output logic [15:0] call_address,
   output logic        opcode_error,
   output logic        ack_done
);
   localparam int MAX_W = (PULSE_WIDTH > GAP_WIDTH)
      ? ((PULSE_WIDTH > RECOVERY_CYCLES) ? PULSE_WIDTH : RECOVERY_CYCLES)
      : ((GAP_WIDTH > RECOVERY_CYCLES) ? GAP_WIDTH : RECOVERY_CYCLES);
   localparam int CW = $clog2(MAX_W) + 1;
   localparam logic [CW-1:0] PW = CW'(PULSE_WIDTH);
   localparam logic [CW-1:0] GW = CW'(GAP_WIDTH);
   localparam logic [CW-1:0] RW = CW'(RECOVERY_CYCLES);

   state_t      state_q, state_d;
   logic        mode_q, mode_d;
   logic [1:0]  pulse_index_q, pulse_index_d;
   logic [7:0]  low_byte_q, low_byte_d;
   logic [7:0]  vector_q, vector_d;
   logic [15:0] call_address_q, call_address_d;
   logic        opcode_error_q, opcode_error_d;
   logic        ack_done_q, ack_done_d;
   logic        inta_n_q, inta_n_d;
   logic        load, terminal, req, last_pulse;
   logic [CW-1:0] load_value;

`ifdef INTA_SYNC_EN
   logic [1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[0], int_request};
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) sync_q <= '0;
      else sync_q <= sync_d;
   assign req = sync_q[1];
`else
   assign req = int_request;
`endif

   inta_pulse_counter #(.W(CW)) u_cnt (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_value (load_value),
      .terminal   (terminal)
   );

   assign last_pulse = (pulse_index_q == (mode_q ? PULSES_8086 - 2'd1 : PULSES_8080 - 2'd1));

   always_comb begin
      state_d        = state_q;
      mode_d         = mode_q;
      pulse_index_d  = pulse_index_q;
      low_byte_d     = low_byte_q;
      vector_d       = vector_q;
      call_address_d = call_address_q;
      opcode_error_d = opcode_error_q;
      ack_done_d     = 1'b0;
      load           = 1'b0;
      load_value     = '0;
      case (state_q)
         IDLE: if (req && interrupt_enable) begin
            state_d        = LOW;
            mode_d         = mode_8086;
            pulse_index_d  = 2'd0;
            opcode_error_d = 1'b0;
            load           = 1'b1;
            load_value     = PW;
         end
         LOW: if (terminal) begin
            // 8080 bytes: opcode check on pulse 0, low address byte held until the final pulse
            if (!mode_q && pulse_index_q == 2'd0 && data_in != CALL_OPCODE) opcode_error_d = 1'b1;
            if (!mode_q && pulse_index_q == 2'd1) low_byte_d = data_in;
            load = 1'b1;
            if (last_pulse) begin
               state_d        = RECOVER;
               load_value     = RW;
               ack_done_d     = 1'b1;
               vector_d       = mode_q ? data_in : vector_q;
               call_address_d = mode_q ? call_address_q : {data_in, low_byte_q};
            end else begin
               state_d    = GAP;
               load_value = GW;
            end
         end
         GAP: if (terminal) begin
            state_d       = LOW;
            pulse_index_d = pulse_index_q + 2'd1;
            load          = 1'b1;
            load_value    = PW;
         end
         RECOVER: if (terminal) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      inta_n_d = (state_d != LOW);
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q        <= IDLE;
         mode_q         <= 1'b0;
         pulse_index_q  <= 2'd0;
         low_byte_q     <= 8'h00;
         vector_q       <= 8'h00;
         call_address_q <= 16'h0000;
         opcode_error_q <= 1'b0;
         ack_done_q     <= 1'b0;
         inta_n_q       <= 1'b1;
      end else begin
         state_q        <= state_d;
         mode_q         <= mode_d;
         pulse_index_q  <= pulse_index_d;
         low_byte_q     <= low_byte_d;
         vector_q       <= vector_d;
         call_address_q <= call_address_d;
         opcode_error_q <= opcode_error_d;
         ack_done_q     <= ack_done_d;
         inta_n_q       <= inta_n_d;
      end

   assign inta_n       = inta_n_q;
   assign busy         = (state_q != IDLE);
   assign vector       = vector_q;
   assign call_address = call_address_q;
   assign opcode_error = opcode_error_q;
   assign ack_done     = ack_done_q;
endmodule
